led_pwm: RTL
============

LED_PWM -- requirements
Module: led_pwm

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of LED channels, legal 1..16.
REQ-002 SHALL have parameter PWM_BITS, default 8, PWM counter/duty width, legal 2..16.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rd_en  input  1  read strobe, one cycle per access.
REQ-006 SHALL have port addr  input  16  register word address, shared by reads and writes.
REQ-007 SHALL have port rd_data  output  32  read data, registered.
REQ-008 SHALL have port rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-009 SHALL have port wr_en  input  1  write strobe, one cycle per access.
REQ-010 SHALL have port wr_data  input  32  write data.
REQ-011 SHALL have port led  output  N_CH  registered LED drive, bit i = channel i.

Function
REQ-012 SHALL decode addr 0x0000 ENABLE: bits [N_CH-1:0] channel enable mask, R/W; upper bits read 0.
REQ-013 SHALL decode addr 0x0001 PRESCALE: bits [15:0] tick divider, R/W.
REQ-014 SHALL decode addr 0x0002 STATUS, RO: [N_CH-1:0] current led, [31:16] zero-extended PWM counter.
REQ-015 SHALL decode addr 0x0010+i (i < N_CH) CFG[i], R/W: [PWM_BITS-1:0] duty, [16] blink mode, [31:24] blink_div; other bits read 0.
REQ-016 SHALL return, for a mapped read, register contents on rd_data with rd_valid=1 on the cycle after rd_en; rd_valid=0 on all other cycles.
REQ-017 SHALL ignore unmapped reads: no rd_valid pulse, rd_data unchanged.
REQ-018 SHALL ignore writes to STATUS and unmapped addresses.
REQ-019 SHALL, on rd_en and wr_en to the same address in one cycle, return the pre-write value and commit the write.
REQ-020 SHALL run a 16-bit prescale counter: tick asserted when counter == PRESCALE, counter then clears; PRESCALE=0 gives a tick every cycle.
REQ-021 SHALL clear the prescale counter on any PRESCALE write.
REQ-022 SHALL advance the PWM counter by 1 per tick, wrapping from 2^PWM_BITS-2 to 0 (period 2^PWM_BITS-1 ticks); the wrap tick is the period boundary.
REQ-023 SHALL hold per-channel active duty and active blink settings, loaded from CFG[i] only at a period boundary (glitch-free update).
REQ-024 SHALL compute raw[i] = (pwm_cnt < active_duty[i]); duty 0 is always off, duty 2^PWM_BITS-1 is always on.
REQ-025 SHALL keep per-channel blink phase and 8-bit blink counter, advanced only at period boundaries while active blink mode=1.
REQ-026 SHALL, at a boundary with blink counter == blink_div, toggle phase and clear counter; otherwise increment counter; blink_div=0 toggles every period.
REQ-027 SHALL force phase=1 and clear blink counter while active blink mode=0.
REQ-028 SHALL register led[i] <= ENABLE[i] & phase[i] & raw[i] every cycle (one-cycle latency from counter state).
REQ-029 SHALL clear led[i] on the cycle after ENABLE[i] is written 0, without waiting for a period boundary.

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear ENABLE, PRESCALE, all CFG, active settings, prescale/PWM/blink counters, led, rd_data, rd_valid; phase resets to 1.
REQ-031 SHALL abandon any in-flight read on reset mid-access: no rd_valid after rst_n rises.
REQ-032 SHALL resume counting on the first clk edge after rst_n deasserts.

Verification
REQ-033 SHALL cover: reset, write ENABLE=0x5, read addr 0 -> rd_data=0x00000005, rd_valid high exactly 1 cycle after rd_en.
REQ-034 SHALL cover: PRESCALE=0, CFG[0].duty=64, ENABLE=1 -> led[0] high 64 of every 255 cycles after first boundary; duty 255 -> constant high; duty 0 -> constant low.
REQ-035 SHALL cover: duty changed 64->128 mid-period -> current period keeps 64 high cycles, next period 128.
REQ-036 SHALL cover: PRESCALE=3, duty=128, blink=1, blink_div=1 -> PWM period 1020 cycles; led PWMs 2 periods, stays low 2 periods, repeats.
REQ-037 SHALL cover: read addr 0x0003 -> no rd_valid; write addr 0x0002 -> STATUS unchanged; simultaneous rd/wr to ENABLE -> old value returned.
REQ-038 SHALL cover: rst_n pulsed low mid-period and during pending read -> led=0, rd_valid=0, all registers read 0 afterwards.

Source files
------------

// File: rtl/led_pwm.sv
// Multi-channel LED PWM controller with a register interface, prescaled PWM
// timebase, period-boundary shadowing of duty/blink settings and per-channel blink.
module led_pwm #(
    parameter int N_CH     = 4,
    parameter int PWM_BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_en,
    input  logic [15:0]     addr,
    output logic [31:0]     rd_data,
    output logic            rd_valid,
    input  logic            wr_en,
    input  logic [31:0]     wr_data,
    output logic [N_CH-1:0] led
);

    localparam logic [15:0]         ADDR_ENABLE   = 16'h0000;
    localparam logic [15:0]         ADDR_PRESCALE = 16'h0001;
    localparam logic [15:0]         ADDR_STATUS   = 16'h0002;
    localparam logic [15:0]         CFG_BASE      = 16'h0010;
    localparam logic [PWM_BITS-1:0] PWM_WRAP      = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [N_CH-1:0]     enable_r;
    logic [15:0]         prescale_r;
    logic [15:0]         presc_cnt_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [N_CH-1:0]     led_r;
    logic [31:0]         rd_data_r;
    logic                rd_valid_r;

    logic                en_we_s;
    logic                ps_we_s;
    logic                tick_s;
    logic                boundary_s;
    logic [N_CH-1:0]     cfg_hit_s;
    logic [N_CH-1:0]     raw_s;
    logic [N_CH-1:0]     phase_s;
    logic [31:0]         cfg_rd_s [N_CH];
    logic                rd_hit_s;
    logic [31:0]         rd_word_s;
    logic                unused_wr_s;

    assign en_we_s     = wr_en && (addr == ADDR_ENABLE);
    assign ps_we_s     = wr_en && (addr == ADDR_PRESCALE);
    assign tick_s      = (presc_cnt_r == prescale_r);
    assign boundary_s  = tick_s && (pwm_cnt_r == PWM_WRAP);
    assign unused_wr_s = ^wr_data[23:17];

    assign led      = led_r;
    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;

    // Global control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_r   <= '0;
            prescale_r <= 16'h0000;
        end else begin
            if (en_we_s) begin
                enable_r <= wr_data[N_CH-1:0];
            end
            if (ps_we_s) begin
                prescale_r <= wr_data[15:0];
            end
        end
    end

    // Prescale tick generator and PWM counter; a PRESCALE write restarts the divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_r <= 16'h0000;
            pwm_cnt_r   <= '0;
        end else begin
            if (ps_we_s || tick_s) begin
                presc_cnt_r <= 16'h0000;
            end else begin
                presc_cnt_r <= presc_cnt_r + 16'd1;
            end
            if (tick_s) begin
                pwm_cnt_r <= boundary_s ? '0 : pwm_cnt_r + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [PWM_BITS-1:0] cfg_duty_r;
        logic                cfg_blink_r;
        logic [7:0]          cfg_div_r;
        logic [PWM_BITS-1:0] act_duty_r;
        logic                act_blink_r;
        logic [7:0]          act_div_r;
        logic [7:0]          blink_cnt_r;
        logic                phase_r;
        logic [31:0]         cfg_word_s;

        assign cfg_hit_s[g] = (addr == CFG_BASE + 16'(g));
        assign raw_s[g]     = (pwm_cnt_r < act_duty_r);
        assign phase_s[g]   = phase_r;
        assign cfg_rd_s[g]  = cfg_hit_s[g] ? cfg_word_s : 32'h0000_0000;

        // Readback image of the programmed channel configuration
        always_comb begin
            cfg_word_s                 = 32'h0000_0000;
            cfg_word_s[PWM_BITS-1:0]   = cfg_duty_r;
            cfg_word_s[16]             = cfg_blink_r;
            cfg_word_s[31:24]          = cfg_div_r;
        end

        // Programmed config, boundary-shadowed active copy, and blink phase
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cfg_duty_r  <= '0;
                cfg_blink_r <= 1'b0;
                cfg_div_r   <= 8'h00;
                act_duty_r  <= '0;
                act_blink_r <= 1'b0;
                act_div_r   <= 8'h00;
                blink_cnt_r <= 8'h00;
                phase_r     <= 1'b1;
            end else begin
                if (wr_en && cfg_hit_s[g]) begin
                    cfg_duty_r  <= wr_data[PWM_BITS-1:0];
                    cfg_blink_r <= wr_data[16];
                    cfg_div_r   <= wr_data[31:24];
                end
                if (boundary_s) begin
                    act_duty_r  <= cfg_duty_r;
                    act_blink_r <= cfg_blink_r;
                    act_div_r   <= cfg_div_r;
                end
                if (!act_blink_r) begin
                    phase_r     <= 1'b1;
                    blink_cnt_r <= 8'h00;
                end else if (boundary_s) begin
                    if (blink_cnt_r == act_div_r) begin
                        phase_r     <= ~phase_r;
                        blink_cnt_r <= 8'h00;
                    end else begin
                        blink_cnt_r <= blink_cnt_r + 8'd1;
                    end
                end
            end
        end
    end

    // Read mux; CFG words are pre-qualified by their own address hit and OR-combined
    always_comb begin
        rd_hit_s  = 1'b0;
        rd_word_s = 32'h0000_0000;
        case (addr)
            ADDR_ENABLE: begin
                rd_hit_s             = 1'b1;
                rd_word_s[N_CH-1:0]  = enable_r;
            end
            ADDR_PRESCALE: begin
                rd_hit_s             = 1'b1;
                rd_word_s[15:0]      = prescale_r;
            end
            ADDR_STATUS: begin
                rd_hit_s             = 1'b1;
                rd_word_s[N_CH-1:0]  = led_r;
                rd_word_s[31:16]     = 16'(pwm_cnt_r);
            end
            default: begin
                rd_hit_s = |cfg_hit_s;
                for (int i = 0; i < N_CH; i++) begin
                    rd_word_s = rd_word_s | cfg_rd_s[i];
                end
            end
        endcase
    end

    // Registered read response and LED drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r  <= 32'h0000_0000;
            rd_valid_r <= 1'b0;
            led_r      <= '0;
        end else begin
            if (rd_en && rd_hit_s) begin
                rd_data_r  <= rd_word_s;
                rd_valid_r <= 1'b1;
            end else begin
                rd_valid_r <= 1'b0;
            end
            led_r <= enable_r & phase_s & raw_s;
        end
    end

endmodule
